// File: rtl/accum_pkg.sv
// ============================================================================
// Module   : accum_pkg
// Purpose  : Shared types and constants for the accum_8bit block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_pkg;

  localparam int ACC_W = 8;
  localparam logic [ACC_W-1:0] SAT_VAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage : accum_pkg

`default_nettype wire

// File: rtl/adder_8bit.sv
// ============================================================================
// Module   : adder_8bit
// Purpose  : Combinational 8-bit ripple-carry adder; overflow is the carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       overflow
);

  logic [8:0] w_carry;

  assign w_carry[0] = carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign overflow = w_carry[8];

endmodule : adder_8bit

`default_nettype wire

// File: rtl/accum_8bit.sv
// ============================================================================
// Module   : accum_8bit
// Purpose  : Block accumulator: sums NUM_SAMPLES handshaked bytes, then holds
//            the sum and a sticky carry flag until consumed downstream.
//            Optional saturation: define ACCUM_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_8bit
  import accum_pkg::*;
#(
  parameter int NUM_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam logic [7:0] c_last_cnt = 8'(NUM_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_accept;
  logic             w_last;

  adder_8bit u_adder (
    .a        (acc_q),
    .b        (in_data),
    .carry_in (1'b0),
    .sum      (w_sum),
    .overflow (w_carry)
  );

`ifdef ACCUM_SATURATE_EN
  // Once saturated, any further add either carries or adds zero, so 0xFF sticks.
  assign w_acc_next = w_carry ? SAT_VAL : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (cnt_q == c_last_cnt);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        // cnt is zero in IDLE, so the same last-sample test covers NUM_SAMPLES==1.
        if (w_accept) begin
          acc_d   = w_acc_next;
          ovf_d   = ovf_q | w_carry;
          cnt_d   = cnt_q + 8'd1;
          state_d = w_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : accum_8bit

`default_nettype wire

// File: tb/tb_accum_8bit.sv
// ============================================================================
// Module   : tb_accum_8bit
// Purpose  : Self-checking bench for accum_8bit: directed vector table plus
//            randomized traffic against a queue-based block-sum model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_8bit;

  localparam int N = 4;

`ifdef ACCUM_SATURATE_EN
  localparam logic [7:0] c_ovf_sum = 8'hFF;
  localparam logic [7:0] c_max_sum = 8'hFF;
  localparam bit         c_sat     = 1'b1;
`else
  localparam logic [7:0] c_ovf_sum = 8'h05;
  localparam logic [7:0] c_max_sum = 8'hFC;
  localparam bit         c_sat     = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;

  int n_total = 0;
  int n_pass  = 0;

  accum_8bit #(.NUM_SAMPLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       eir;
    logic       eov;
    logic [7:0] esum;
    logic       eovf;
    bit         chk;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic r, input logic iv, input logic [7:0] d,
                     input logic ordy, input logic eir, input logic eov,
                     input bit chk, input logic [7:0] esum, input logic eovf);
    vec_t v;
    v.name = nm; v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.chk = chk; v.esum = esum; v.eovf = eovf;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: block sum recomputed from the accepted samples with plain integers.
  function automatic logic [8:0] block_sum(input logic [7:0] q[$]);
    int s = 0;
    bit o = 0;
    foreach (q[i]) begin
      int t = s + int'(q[i]);
      if (t > 255) begin
        o = 1;
        s = c_sat ? 255 : t - 256;
      end else begin
        s = t;
      end
    end
    return {o, 8'(s)};
  endfunction

  initial begin
    logic [7:0] m_blk[$];
    bit         m_hold;
    logic [8:0] m_res;

    // name, rst, iv, d, ordy, eir, eov, chk, esum, eovf
    add("reset0", 1, 0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    add("reset1", 1, 0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    add("b1_s1",  0, 1, 8'h01, 1, 1, 0, 0, 8'h00, 0);
    add("b1_s2",  0, 1, 8'h02, 1, 1, 0, 0, 8'h00, 0);
    add("b1_s3",  0, 1, 8'h03, 1, 1, 0, 0, 8'h00, 0);
    add("b1_res", 0, 1, 8'h04, 1, 0, 1, 1, 8'h0A, 0);
    add("b1_done",0, 1, 8'h77, 1, 1, 0, 1, 8'h00, 0);
    add("ov_s1",  0, 1, 8'h80, 1, 1, 0, 0, 8'h00, 0);
    add("ov_s2",  0, 1, 8'h80, 1, 1, 0, 0, 8'h00, 0);
    add("ov_s3",  0, 1, 8'h05, 1, 1, 0, 0, 8'h00, 0);
    add("ov_res", 0, 1, 8'h00, 1, 0, 1, 1, c_ovf_sum, 1);
    add("ov_done",0, 0, 8'h00, 1, 1, 0, 1, 8'h00, 0);
    add("mx_s1",  0, 1, 8'hFF, 0, 1, 0, 0, 8'h00, 0);
    add("mx_s2",  0, 1, 8'hFF, 0, 1, 0, 0, 8'h00, 0);
    add("mx_s3",  0, 1, 8'hFF, 0, 1, 0, 0, 8'h00, 0);
    add("mx_res", 0, 1, 8'hFF, 0, 0, 1, 1, c_max_sum, 1);
    add("mx_done",0, 0, 8'h00, 1, 1, 0, 1, 8'h00, 0);
    // gapped valid 1,0,0,1,1,0,1 with downstream stalled
    add("gap1",   0, 1, 8'h10, 0, 1, 0, 0, 8'h00, 0);
    add("gap2",   0, 0, 8'hEE, 0, 1, 0, 0, 8'h00, 0);
    add("gap3",   0, 0, 8'hEE, 0, 1, 0, 0, 8'h00, 0);
    add("gap4",   0, 1, 8'h10, 0, 1, 0, 0, 8'h00, 0);
    add("gap5",   0, 1, 8'h10, 0, 1, 0, 0, 8'h00, 0);
    add("gap6",   0, 0, 8'hEE, 0, 1, 0, 0, 8'h00, 0);
    add("gap_res",0, 1, 8'h10, 0, 0, 1, 1, 8'h40, 0);
    for (int i = 0; i < 5; i++)
      add("bp_hold", 0, 1, 8'h55, 0, 0, 1, 1, 8'h40, 0);
    add("bp_rel", 0, 1, 8'h55, 1, 1, 0, 1, 8'h00, 0);
    // reset mid-block
    add("rm_s1",  0, 1, 8'h20, 0, 1, 0, 0, 8'h00, 0);
    add("rm_s2",  0, 1, 8'h30, 0, 1, 0, 0, 8'h00, 0);
    add("rm_rst", 1, 1, 8'h99, 0, 1, 0, 1, 8'h00, 0);
    add("rm_a1",  0, 1, 8'h01, 0, 1, 0, 0, 8'h00, 0);
    add("rm_a2",  0, 1, 8'h01, 0, 1, 0, 0, 8'h00, 0);
    add("rm_a3",  0, 1, 8'h01, 0, 1, 0, 0, 8'h00, 0);
    add("rm_res", 0, 1, 8'h01, 0, 0, 1, 1, 8'h04, 0);
    add("rh_rst", 1, 0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
    add("idle",   0, 0, 8'h00, 1, 1, 0, 1, 8'h00, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      check({tbl[i].name, "_in_ready"},  32'(in_ready),  32'(tbl[i].eir));
      check({tbl[i].name, "_out_valid"}, 32'(out_valid), 32'(tbl[i].eov));
      if (tbl[i].chk) begin
        check({tbl[i].name, "_out_sum"}, 32'(out_sum), 32'(tbl[i].esum));
        check({tbl[i].name, "_out_ovf"}, 32'(out_ovf), 32'(tbl[i].eovf));
      end
    end

    // Randomized traffic; the table leaves the DUT idle with an empty block.
    m_blk.delete();
    m_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      if (rst) begin
        m_blk.delete();
        m_hold = 1'b0;
      end else if (m_hold) begin
        if (out_ready) begin
          m_blk.delete();
          m_hold = 1'b0;
        end
      end else if (in_valid) begin
        m_blk.push_back(in_data);
        if (m_blk.size() == N) m_hold = 1'b1;
      end
      m_res = block_sum(m_blk);
      check("rnd_in_ready",  32'(in_ready),  32'(!m_hold));
      check("rnd_out_valid", 32'(out_valid), 32'(m_hold));
      check("rnd_out_sum",   32'(out_sum),   32'(m_res[7:0]));
      check("rnd_out_ovf",   32'(out_ovf),   32'(m_res[8]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_accum_8bit

`default_nettype wire
